// File: rtl/spi_slave_target.sv
// SPI mode-0 target endpoint. Pins are synchronized into clk, edge strobes
// drive a small FSM that shifts 32-bit words in on sclk rise and out on
// sclk fall. Words received go out on a valid/ready stream, and words to
// send come in on a fetch-strobe stream.
// Optional build macro SPI_SLAVE_ERR_CNT_EN adds saturating underrun/overrun
// event counters on err_cnt_o. Without it, err_cnt_o is tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | chip select high, MISO pad disabled
// ST_FETCH | one cycle: pull first tx word, drive its MSB, enable pad
// ST_SHIFT | shifting; every 32nd rise completes rx and refetches tx
module spi_slave_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        spi_sclk,
  input  logic        spi_csn,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  output logic [31:0] rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  input  logic [31:0] tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [3:0]  status_o,
  input  logic        status_clr_i,
  output logic [15:0] err_cnt_o,
  output logic        eot_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SHIFT} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, sdi_sync_q;
  logic sclk_s, csn_s, sdi_s;
  logic sclk_prev_q, csn_prev_q, sdi_q;
  logic rise_q, fall_q, cs_fall_q, cs_rise_q;

  state_e      state_q;
  logic [4:0]  bit_cnt_q;
  logic [30:0] rx_sr_q;
  logic [31:0] tx_sr_q;
  logic        sdo_q, sdo_oe_q;
  logic [31:0] rx_data_q;
  logic        rx_valid_q;
  logic        frag_q, underrun_q, overrun_q;

  logic        word_done;
  logic [31:0] fetch_word;
  logic [31:0] rx_word;
  logic        underrun_ev, overrun_ev, frag_ev;

  // Pin synchronizers; csn idles high so reset it high to avoid a false cs edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      sdi_sync_q  <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];

  // Registered edge strobes; sdi is delayed alongside so it lines up with rise_q.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
      sdi_q       <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
      sdi_q       <= sdi_s;
      rise_q      <= sclk_s & ~sclk_prev_q;
      fall_q      <= ~sclk_s & sclk_prev_q;
      cs_fall_q   <= ~csn_s & csn_prev_q;
      cs_rise_q   <= csn_s & ~csn_prev_q;
    end
  end

  assign word_done   = (state_q == ST_SHIFT) & rise_q & ~cs_rise_q & (bit_cnt_q == 5'd31);
  assign tx_ready_o  = (state_q == ST_FETCH) | word_done;
  assign fetch_word  = tx_valid_i ? tx_data_i : 32'hFFFF_FFFF;
  assign rx_word     = {rx_sr_q, sdi_q};
  assign underrun_ev = tx_ready_o & ~tx_valid_i;
  assign overrun_ev  = word_done & rx_valid_q & ~rx_ready_i;
  assign frag_ev     = cs_rise_q & (bit_cnt_q != 5'd0);

  // Main FSM: cs_rise wins over everything and returns to idle from any state.
  // A tx word reloaded on the 32nd rise leaves through the normal fall shift,
  // so its MSB goes out on the very next fall with no extra pending flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      sdo_q      <= 1'b0;
      sdo_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      if (rx_ready_i) rx_valid_q <= 1'b0;
      if (cs_rise_q) begin
        state_q   <= ST_IDLE;
        sdo_oe_q  <= 1'b0;
        bit_cnt_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            sdo_oe_q <= 1'b0;
            if (cs_fall_q) state_q <= ST_FETCH;
          end
          ST_FETCH: begin
            sdo_q     <= fetch_word[31];
            tx_sr_q   <= {fetch_word[30:0], 1'b0};
            bit_cnt_q <= '0;
            sdo_oe_q  <= 1'b1;
            state_q   <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (rise_q) begin
              rx_sr_q   <= rx_word[30:0];
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (word_done) begin
                if (!rx_valid_q || rx_ready_i) begin
                  rx_data_q  <= rx_word;
                  rx_valid_q <= 1'b1;
                end
                tx_sr_q <= fetch_word;
              end
            end else if (fall_q) begin
              sdo_q   <= tx_sr_q[31];
              tx_sr_q <= {tx_sr_q[30:0], 1'b0};
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Sticky error flags: a new event in the clear cycle keeps the bit set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frag_q     <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      frag_q     <= frag_ev     | (frag_q     & ~status_clr_i);
      underrun_q <= underrun_ev | (underrun_q & ~status_clr_i);
      overrun_q  <= overrun_ev  | (overrun_q  & ~status_clr_i);
    end
  end

`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0] und_cnt_q, ovr_cnt_q;

  // Saturating event counters; an event in the clear cycle leaves a count of one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      und_cnt_q <= '0;
      ovr_cnt_q <= '0;
    end else begin
      if (underrun_ev) begin
        if (status_clr_i)            und_cnt_q <= 8'd1;
        else if (und_cnt_q != 8'hFF) und_cnt_q <= und_cnt_q + 8'd1;
      end else if (status_clr_i) begin
        und_cnt_q <= '0;
      end
      if (overrun_ev) begin
        if (status_clr_i)            ovr_cnt_q <= 8'd1;
        else if (ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
      end else if (status_clr_i) begin
        ovr_cnt_q <= '0;
      end
    end
  end

  assign err_cnt_o = {und_cnt_q, ovr_cnt_q};
`else
  assign err_cnt_o = 16'h0;
`endif

  assign spi_sdo    = sdo_q;
  assign spi_sdo_oe = sdo_oe_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign status_o   = {(state_q != ST_IDLE), frag_q, underrun_q, overrun_q};
  assign eot_o      = cs_rise_q;

endmodule

// File: tb/tb_spi_slave_target.sv
// Bench for spi_slave_target: a bit-banged SPI master with random frames,
// a tx fifo emulation, and an rx scoreboard popped by a monitor.
module tb_spi_slave_target;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        spi_sclk = 1'b0, spi_csn = 1'b1, spi_sdi = 1'b0;
  logic        spi_sdo, spi_sdo_oe;
  logic [31:0] rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b1;
  logic [31:0] tx_data_i = '0;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [3:0]  status_o;
  logic        status_clr_i = 1'b0;
  logic [15:0] err_cnt_o;
  logic        eot_o;

  spi_slave_target #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .status_o(status_o), .status_clr_i(status_clr_i), .err_cnt_o(err_cnt_o), .eot_o(eot_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, eot_cnt = 0;
  bit tx_pend = 1'b0;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mosi_w [0:3];
  bit m_rxv = 1'b0, m_frag = 1'b0, m_und = 1'b0, m_ovr = 1'b0;
  int m_ovr_cnt = 0, m_und_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_err();
`ifdef SPI_SLAVE_ERR_CNT_EN
    return {m_und_cnt[7:0], m_ovr_cnt[7:0]};
`else
    return 16'h0;
`endif
  endfunction

  function automatic void clear_model();
    m_frag = 1'b0; m_und = 1'b0; m_ovr = 1'b0;
    m_ovr_cnt = 0; m_und_cnt = 0;
  endfunction

  // tx fifo emulation: a word is popped one cycle after the strobe that consumed it
  always @(negedge clk) begin
    if (tx_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    tx_pend    = tx_ready_o && tx_valid_i;
    tx_valid_i = (fifo_q.size() > 0);
    tx_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
  end

  // rx monitor: every accepted word must match the scoreboard head
  always @(negedge clk) begin
    if (eot_o) eot_cnt++;
    if (rx_valid_o && rx_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rx_unexpected actual=%0h expected=none", rx_data_o);
      end else begin
        check("rx_word", 64'(rx_data_o), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic rand_mosi();
    for (int k = 0; k < 4; k++) mosi_w[k] = $urandom;
  endtask

  task automatic push_tx(input int n);
    for (int k = 0; k < n; k++) fifo_q.push_back($urandom);
  endtask

  task automatic run_frame(input int nbits, input bit do_reset);
    logic [31:0] snap[$];
    logic [31:0] ew;
    int fetches, eot0, pops;
    snap    = fifo_q;
    eot0    = eot_cnt;
    fetches = nbits / 32 + 1;
    spi_csn = 1'b0;
    tick(10);
    for (int i = 0; i < nbits; i++) begin
      spi_sdi = mosi_w[i/32][31 - (i % 32)];
      tick(HALF);
      ew = ((i / 32) < snap.size()) ? snap[i/32] : 32'hFFFF_FFFF;
      check("miso_bit", 64'(spi_sdo), 64'(ew[31 - (i % 32)]));
      spi_sclk = 1'b1;
      if ((i % 32) == 31) begin
        if (!m_rxv || rx_ready_i) begin
          exp_q.push_back(mosi_w[i/32]);
          m_rxv = !rx_ready_i;
        end else begin
          m_ovr = 1'b1;
          if (m_ovr_cnt < 255) m_ovr_cnt++;
        end
      end
      tick(HALF);
      spi_sclk = 1'b0;
    end
    tick(HALF);
    if ((nbits % 32) != 0) m_frag = 1'b1;
    if (fetches > snap.size()) begin
      m_und = 1'b1;
      m_und_cnt = m_und_cnt + (fetches - snap.size());
      if (m_und_cnt > 255) m_und_cnt = 255;
    end
    if (!do_reset) begin
      spi_csn = 1'b1;
      tick(12);
      pops = (fetches < snap.size()) ? fetches : snap.size();
      check("eot_count", 64'(eot_cnt - eot0), 64'd1);
      check("tx_pops", 64'(snap.size() - fifo_q.size()), 64'(pops));
      check("status", 64'(status_o), 64'({1'b0, m_frag, m_und, m_ovr}));
      check("err_cnt", 64'(err_cnt_o), 64'(exp_err()));
      check("sdo_oe_idle", 64'(spi_sdo_oe), 64'd0);
      status_clr_i = 1'b1;
      tick(1);
      status_clr_i = 1'b0;
      clear_model();
      tick(1);
      check("status_clr", 64'({status_o, err_cnt_o}), 64'd0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sdo"},      64'(spi_sdo),    64'd0);
    check({tag, "_sdo_oe"},   64'(spi_sdo_oe), 64'd0);
    check({tag, "_rx_data"},  64'(rx_data_o),  64'd0);
    check({tag, "_rx_valid"}, 64'(rx_valid_o), 64'd0);
    check({tag, "_tx_ready"}, 64'(tx_ready_o), 64'd0);
    check({tag, "_eot"},      64'(eot_o),      64'd0);
    check({tag, "_status"},   64'(status_o),   64'd0);
    check({tag, "_err_cnt"},  64'(err_cnt_o),  64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, fill;
    #1;
    check_reset_vals("reset");
    tick(3);
    rstn = 1'b1;
    tick(5);

    // single word with known pattern
    fifo_q.push_back(32'h1234_5678);
    push_tx(1);
    rand_mosi();
    mosi_w[0] = 32'hA5A5_0F0F;
    run_frame(32, 1'b0);

    // three back-to-back words, fifo deep enough to avoid underrun
    push_tx(4);
    rand_mosi();
    run_frame(96, 1'b0);
    check("b2b_rx_valid", 64'(rx_valid_o), 64'd0);

    // overrun: downstream stalled for two words
    rx_ready_i = 1'b0;
    push_tx(3);
    rand_mosi();
    run_frame(64, 1'b0);
    check("ovr_hold_data", 64'(rx_data_o), 64'(mosi_w[0]));
    check("ovr_hold_valid", 64'(rx_valid_o), 64'd1);
    rx_ready_i = 1'b1;
    tick(3);
    m_rxv = 1'b0;
    check("ovr_drained", 64'(exp_q.size()), 64'd0);

    // underrun: empty fifo yields all-ones on MISO
    fifo_q.delete();
    tick(2);
    rand_mosi();
    run_frame(32, 1'b0);

    // fragment then a clean frame
    push_tx(2);
    rand_mosi();
    run_frame(13, 1'b0);
    push_tx(2);
    rand_mosi();
    run_frame(32, 1'b0);

    // randomized frames
    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 3))
        0: nb = 32;
        1: nb = 64;
        2: nb = 96;
        default: nb = $urandom_range(1, 100);
      endcase
      fill = $urandom_range(0, 4);
      push_tx(fill);
      rand_mosi();
      rx_ready_i = ($urandom_range(0, 3) != 0);
      run_frame(nb, 1'b0);
      if (!rx_ready_i) begin
        rx_ready_i = 1'b1;
        tick(3);
        m_rxv = 1'b0;
      end
    end

    // reset in the middle of a word, then a fresh frame
    push_tx(2);
    rand_mosi();
    run_frame(20, 1'b1);
    rstn = 1'b0;
    #1;
    check_reset_vals("midrst");
    spi_csn = 1'b1;
    spi_sdi = 1'b0;
    tick(3);
    rstn = 1'b1;
    m_rxv = 1'b0;
    clear_model();
    tick(5);
    push_tx(2);
    rand_mosi();
    run_frame(32, 1'b0);

    tick(5);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
